nibble_serial_adder: RTL



---
 rtl/nibble_serial_adder_if.sv | 40 ++++
 rtl/nibble_serial_adder.sv | 122 ++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_if.sv
// Client-side handshake bundle for nibble_serial_adder: operand request and result channels.
// The ovf signal exists only when SERIAL_ADD_OVF_EN is defined.
interface nibble_serial_adder_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif
endinterface

// File: rtl/nibble_serial_adder.sv
// Wide adder that ripples one 4-bit nibble per clock through an fa4 full adder.
// Optional signed-overflow flag is built when SERIAL_ADD_OVF_EN is defined.
module fa4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] Sum,
  output logic       Cout
);
  assign {Cout, Sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  nibble_serial_adder_if.slave bus
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     sum_q;
  logic             carry_q;
  logic             cout_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic [3:0]       fa_a;
  logic [3:0]       fa_b;
  logic [3:0]       fa_sum;
  logic             fa_cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q;
`endif

  assign fa_a  = a_q[4*idx_q +: 4];
  assign fa_b  = b_q[4*idx_q +: 4];
  assign idx_d = idx_q + 1'b1;

  fa4 u_fa4 (
    .a    (fa_a),
    .b    (fa_b),
    .cin  (carry_q),
    .Sum  (fa_sum),
    .Cout (fa_cout)
  );

  // Handshake flags are registered copies of the state decode, updated with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            carry_q    <= bus.cin;
            idx_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
          end
        end
        RUN: begin
          sum_q[4*idx_q +: 4] <= fa_sum;
          carry_q             <= fa_cout;
          idx_q               <= idx_d;
          if (idx_q == LAST) begin
            cout_q      <= fa_cout;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
            // fa_sum[3] is the result sign bit on the top nibble.
            ovf_q <= (a_q[W-1] == b_q[W-1]) && (fa_sum[3] != a_q[W-1]);
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf       = ovf_q;
`endif
endmodule
